nrisc_mem_responder: RTL and testbench
======================================

// Module: nrisc_mem_responder
// PURPOSE
// - Memory-side responder for the nRisc core: serves instruction fetch (PC_inst -> saidaInstruction)
//   and data load/store (endereco/dado/LEmem/ESCREVEmem -> saidaDadoMem).
// - Holds the core off (cpu_run=0) while a boot-loader FSM fills instruction memory from a byte stream.
// - Maps one data address to an output register with a strobe, so programs can emit results.
// PARAMETERS
// - ADDR_W   8      address width; each memory is 2**ADDR_W words
// - DATA_W   8      data / instruction word width
// - IO_ADDR  8'hFF  data address decoded as the output port, not as RAM
// PORTS
// - clock            in   1       system clock, rising edge
// - reset            in   1       asynchronous, active-high
// - PC_inst          in   ADDR_W  fetch address from core
// - saidaInstruction out  DATA_W  instruction word at PC_inst
// - endereco         in   ADDR_W  data address from core
// - dado             in   DATA_W  store data from core
// - LEmem            in   1       load request
// - ESCREVEmem       in   1       store request
// - saidaDadoMem     out  DATA_W  load data to core
// - load_valid       in   1       boot byte valid
// - load_data        in   8       boot byte
// - load_ready       out  1       responder accepts boot byte
// - cpu_run          out  1       program loaded; core may execute
// - io_out           out  DATA_W  last value stored to IO_ADDR
// - io_strobe        out  1       one-cycle pulse on each IO_ADDR store
// BEHAVIOUR
// - Reset (async assert, sync release): state=BOOT_LEN, cnt=0, len=0, cpu_run=0, io_out=0,
//   io_strobe=0. RAM contents not cleared. Reset mid-load returns to BOOT_LEN; partial image kept.
// - FSM: BOOT_LEN -> BOOT_DATA -> RUN; RUN is left only by reset.
//   - load_ready = 1 in BOOT_LEN/BOOT_DATA, 0 in RUN. Byte accepted on edge with load_valid&load_ready.
//   - BOOT_LEN: accepted byte -> len (9 bits); 0 means 256 (2**ADDR_W). cnt<=0; go BOOT_DATA.
//   - BOOT_DATA: accepted byte written to imem[cnt]; cnt++; when cnt==len-1 on accept, go RUN.
//   - load_valid=0 stalls the FSM indefinitely; no timeout.
// - cpu_run = (state==RUN), registered; first 1 the cycle after the last byte is accepted.
// - Instruction fetch: combinational async read, zero latency; saidaInstruction = imem[PC_inst]
//   in RUN, 8'h00 otherwise.
// - Data load: combinational; saidaDadoMem = (LEmem & RUN) ? (endereco==IO_ADDR ? io_out
//   : dmem[endereco]) : 0.
// - Data store: on rising edge when ESCREVEmem & RUN.
//   - endereco!=IO_ADDR: dmem[endereco] <= dado.
//   - endereco==IO_ADDR: io_out <= dado, io_strobe=1 next cycle only; dmem untouched.
//   - Stores outside RUN are dropped.
// - LEmem & ESCREVEmem same cycle, same address: read returns old value; new value visible next cycle.
// - Widths: cnt/len 9 bits; address compare full ADDR_W; no wrap except cnt max 255 at len=256.
// STRUCTURE
// - Package nrisc_mem_pkg: state enum {BOOT_LEN, BOOT_DATA, RUN}, IO_ADDR default, LEN_W=ADDR_W+1.
// - Sub-module nrisc_ram: 2**ADDR_W x DATA_W, sync write / async read, no reset; instantiated
//   twice (imem written only by boot FSM, dmem only by core stores).
// - Top holds FSM, cnt/len, io_out/io_strobe, output muxing.
// TESTING
// - Reset then bytes 03,A1,B2,C3 back-to-back -> imem[0..2]=A1,B2,C3; cpu_run=1 one cycle after C3;
//   PC_inst=1 -> saidaInstruction=B2.
// - Length byte 00 then 256 bytes (value=index) -> cpu_run only after byte 256; imem[255]=FF.
// - Gaps in load_valid mid-stream -> identical image; load_ready=0 once in RUN.
// - RUN: store 5A to 10, then LEmem at 10 -> saidaDadoMem=5A; same-cycle load+store 77 to 10 reads 5A
//   that cycle, 77 next.
// - Store 3C to FF -> io_out=3C, io_strobe high exactly one cycle, dmem[FF] unchanged;
//   load FF -> 3C.
// - Assert reset after 2 of 4 boot bytes -> cpu_run=0, FSM back in BOOT_LEN; stores before RUN ignored.

Source files
------------

// File: rtl/nrisc_mem_pkg.sv
// rtl/nrisc_mem_pkg.sv - shared types and defaults for the nRisc memory responder
package nrisc_mem_pkg;

  // Default geometry: 256 words of 8 bits, output port at the top data address
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_IO_ADDR = 'hFF;

  // Boot length/counter width: one extra bit so a full memory (2**ADDR_W) is representable
  localparam int LEN_W = DEF_ADDR_W + 1;

  // Boot-loader progression; RUN is left only through reset
  typedef enum logic [1:0] {
    BOOT_LEN  = 2'd0,
    BOOT_DATA = 2'd1,
    RUN       = 2'd2
  } bootState_t;

endpackage

// File: rtl/nrisc_ram.sv
// rtl/nrisc_ram.sv - single-port-write, async-read word memory without reset
module nrisc_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Synchronous write; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read is combinational, so a same-cycle write is seen only after the edge
  assign rdata = mem[raddr];

endmodule

// File: rtl/nrisc_mem_responder.sv
// rtl/nrisc_mem_responder.sv - boot loader, instruction/data memories and output port for the nRisc core
module nrisc_mem_responder
  import nrisc_mem_pkg::*;
#(
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter int                DATA_W  = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(DEF_IO_ADDR)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC_inst,
  output logic [DATA_W-1:0] saidaInstruction,
  input  logic [ADDR_W-1:0] endereco,
  input  logic [DATA_W-1:0] dado,
  input  logic              LEmem,
  input  logic              ESCREVEmem,
  output logic [DATA_W-1:0] saidaDadoMem,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic              cpu_run,
  output logic [DATA_W-1:0] io_out,
  output logic              io_strobe
);

  localparam int LW = ADDR_W + 1;

  bootState_t        state;
  logic [LW-1:0]     bootCnt;
  logic [LW-1:0]     bootLen;
  logic              isRun;
  logic              byteTaken;
  logic              imemWe;
  logic              dmemWe;
  logic              ioHit;
  logic [DATA_W-1:0] imemRd;
  logic [DATA_W-1:0] dmemRd;

  assign isRun      = (state == RUN);
  assign load_ready = !isRun;
  assign byteTaken  = load_valid && load_ready;
  assign cpu_run    = isRun;

  assign ioHit  = (endereco == IO_ADDR);
  assign imemWe = byteTaken && (state == BOOT_DATA);
  assign dmemWe = isRun && ESCREVEmem && !ioHit;

  // Boot FSM: length byte first (0 encodes a full memory), then that many image bytes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= BOOT_LEN;
      bootCnt <= '0;
      bootLen <= '0;
    end else begin
      case (state)
        BOOT_LEN: begin
          if (byteTaken) begin
            bootLen <= (load_data == 8'd0) ? LW'(1 << ADDR_W) : LW'(load_data);
            bootCnt <= '0;
            state   <= BOOT_DATA;
          end
        end
        BOOT_DATA: begin
          if (byteTaken) begin
            bootCnt <= bootCnt + LW'(1);
            if (bootCnt == bootLen - LW'(1)) begin
              state <= RUN;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output port: latch the stored value and pulse the strobe for one cycle per store
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_out    <= '0;
      io_strobe <= 1'b0;
    end else begin
      io_strobe <= 1'b0;
      if (isRun && ESCREVEmem && ioHit) begin
        io_out    <= dado;
        io_strobe <= 1'b1;
      end
    end
  end

  nrisc_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_imem (
    .clock (clock),
    .we    (imemWe),
    .waddr (bootCnt[ADDR_W-1:0]),
    .wdata (DATA_W'(load_data)),
    .raddr (PC_inst),
    .rdata (imemRd)
  );

  nrisc_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_dmem (
    .clock (clock),
    .we    (dmemWe),
    .waddr (endereco),
    .wdata (dado),
    .raddr (endereco),
    .rdata (dmemRd)
  );

  // Core-facing read paths are gated so nothing leaks out before the image is complete
  always_comb begin
    saidaInstruction = '0;
    saidaDadoMem     = '0;
    if (isRun) begin
      saidaInstruction = imemRd;
      if (LEmem) begin
        saidaDadoMem = ioHit ? io_out : dmemRd;
      end
    end
  end

endmodule

// File: tb/tb_nrisc_mem_responder.sv
// tb/tb_nrisc_mem_responder.sv - self-checking bench for the nRisc memory responder
module tb_nrisc_mem_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] PC_inst = '0;
  logic [7:0] saidaInstruction;
  logic [7:0] endereco = '0;
  logic [7:0] dado = '0;
  logic       LEmem = 1'b0;
  logic       ESCREVEmem = 1'b0;
  logic [7:0] saidaDadoMem;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_ready;
  logic       cpu_run;
  logic [7:0] io_out;
  logic       io_strobe;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays describing what the memories and port should hold
  logic [7:0] imemModel [256];
  logic [7:0] dmemModel [256];
  bit         dmemKnown [256];
  logic [7:0] ioModel = '0;
  logic [7:0] stim [256];

  nrisc_mem_responder dut (
    .clock            (clock),
    .reset            (reset),
    .PC_inst          (PC_inst),
    .saidaInstruction (saidaInstruction),
    .endereco         (endereco),
    .dado             (dado),
    .LEmem            (LEmem),
    .ESCREVEmem       (ESCREVEmem),
    .saidaDadoMem     (saidaDadoMem),
    .load_valid       (load_valid),
    .load_data        (load_data),
    .load_ready       (load_ready),
    .cpu_run          (cpu_run),
    .io_out           (io_out),
    .io_strobe        (io_strobe)
  );

  always #5 clock = ~clock;

  task automatic pulseReset();
    @(negedge clock);
    reset = 1'b1; load_valid = 1'b0; LEmem = 1'b0; ESCREVEmem = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    ioModel = '0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gapMax);
    repeat ($urandom_range(0, gapMax)) @(negedge clock);
    @(negedge clock);
    load_valid = 1'b1; load_data = b;
    @(posedge clock);
    #1 load_valid = 1'b0;
  endtask

  task automatic storeWord(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    endereco = a; dado = d; ESCREVEmem = 1'b1;
    @(posedge clock);
    #1 ESCREVEmem = 1'b0;
  endtask

  task automatic test_reset();
    pulseReset();
    LEmem = 1'b1; endereco = 8'h10; PC_inst = 8'h00;
    #1;
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL reset_cpu_run got %h want 0", cpu_run); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %h want 1", load_ready); end
    checks++; if (io_out !== 8'h00) begin errors++; $display("FAIL reset_io_out got %h want 00", io_out); end
    checks++; if (io_strobe !== 1'b0) begin errors++; $display("FAIL reset_io_strobe got %h want 0", io_strobe); end
    checks++; if (saidaInstruction !== 8'h00) begin errors++; $display("FAIL reset_instr got %h want 00", saidaInstruction); end
    checks++; if (saidaDadoMem !== 8'h00) begin errors++; $display("FAIL reset_load got %h want 00", saidaDadoMem); end
    LEmem = 1'b0;
  endtask

  // Boot an n-byte image from stim[]; cpu_run must rise only after the last byte
  task automatic test_boot(input string name, input int n, input int gapMax);
    pulseReset();
    sendByte(8'(n), gapMax);
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL %s run_after_len got %h want 0", name, cpu_run); end
    for (int i = 0; i < n; i++) begin
      imemModel[i] = stim[i];
      sendByte(stim[i], gapMax);
      checks++;
      if (cpu_run !== (i == n - 1)) begin
        errors++; $display("FAIL %s run_after_byte%0d got %h want %h", name, i, cpu_run, (i == n - 1));
      end
    end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL %s ready_in_run got %h want 0", name, load_ready); end
    for (int a = 0; a < n; a++) begin
      PC_inst = 8'(a);
      #1;
      checks++;
      if (saidaInstruction !== imemModel[a]) begin
        errors++; $display("FAIL %s fetch[%0d] got %h want %h", name, a, saidaInstruction, imemModel[a]);
      end
    end
  endtask

  task automatic test_boot_short();
    stim[0] = 8'hA1; stim[1] = 8'hB2; stim[2] = 8'hC3;
    test_boot("short", 3, 0);
    PC_inst = 8'd1;
    #1;
    checks++; if (saidaInstruction !== 8'hB2) begin errors++; $display("FAIL short_pc1 got %h want B2", saidaInstruction); end
  endtask

  task automatic test_data_ram();
    logic [7:0] a;
    logic [7:0] d;
    storeWord(8'h10, 8'h5A); dmemModel[8'h10] = 8'h5A; dmemKnown[8'h10] = 1'b1;
    checks++; if (io_strobe !== 1'b0) begin errors++; $display("FAIL ram_no_strobe got %h want 0", io_strobe); end
    @(negedge clock);
    endereco = 8'h10; LEmem = 1'b0;
    #1;
    checks++; if (saidaDadoMem !== 8'h00) begin errors++; $display("FAIL ram_no_le got %h want 00", saidaDadoMem); end
    LEmem = 1'b1;
    #1;
    checks++; if (saidaDadoMem !== 8'h5A) begin errors++; $display("FAIL ram_load10 got %h want 5A", saidaDadoMem); end
    // Same-cycle load and store: old value now, new value after the edge
    @(negedge clock);
    dado = 8'h77; ESCREVEmem = 1'b1;
    #1;
    checks++; if (saidaDadoMem !== 8'h5A) begin errors++; $display("FAIL ram_rw_old got %h want 5A", saidaDadoMem); end
    @(posedge clock);
    #1 ESCREVEmem = 1'b0; dmemModel[8'h10] = 8'h77;
    checks++; if (saidaDadoMem !== 8'h77) begin errors++; $display("FAIL ram_rw_new got %h want 77", saidaDadoMem); end
    LEmem = 1'b0;
    for (int k = 0; k < 24; k++) begin
      a = 8'($urandom_range(0, 254));
      d = 8'($urandom);
      storeWord(a, d);
      dmemModel[a] = d; dmemKnown[a] = 1'b1;
    end
    LEmem = 1'b1;
    for (int i = 0; i < 255; i++) begin
      if (dmemKnown[i]) begin
        endereco = 8'(i);
        #1;
        checks++;
        if (saidaDadoMem !== dmemModel[i]) begin
          errors++; $display("FAIL ram_load[%0d] got %h want %h", i, saidaDadoMem, dmemModel[i]);
        end
      end
    end
    LEmem = 1'b0;
  endtask

  task automatic test_io();
    storeWord(8'hFF, 8'h3C); ioModel = 8'h3C;
    checks++; if (io_out !== ioModel) begin errors++; $display("FAIL io_out got %h want %h", io_out, ioModel); end
    checks++; if (io_strobe !== 1'b1) begin errors++; $display("FAIL io_strobe_hi got %h want 1", io_strobe); end
    @(posedge clock);
    #1;
    checks++; if (io_strobe !== 1'b0) begin errors++; $display("FAIL io_strobe_lo got %h want 0", io_strobe); end
    LEmem = 1'b1; endereco = 8'hFF;
    #1;
    checks++; if (saidaDadoMem !== 8'h3C) begin errors++; $display("FAIL io_load got %h want 3C", saidaDadoMem); end
    endereco = 8'h10;
    #1;
    checks++; if (saidaDadoMem !== dmemModel[8'h10]) begin errors++; $display("FAIL io_ram_kept got %h want %h", saidaDadoMem, dmemModel[8'h10]); end
    LEmem = 1'b0;
  endtask

  task automatic test_partial_reset();
    storeWord(8'h20, 8'h11); dmemModel[8'h20] = 8'h11; dmemKnown[8'h20] = 1'b1;
    pulseReset();
    sendByte(8'h04, 0); sendByte(8'hDE, 0); sendByte(8'hAD, 0);
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL partial_mid got %h want 0", cpu_run); end
    pulseReset();
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL partial_run got %h want 0", cpu_run); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL partial_ready got %h want 1", load_ready); end
    storeWord(8'h20, 8'h99);
    storeWord(8'hFF, 8'h55);
    checks++; if (io_strobe !== 1'b0) begin errors++; $display("FAIL preboot_strobe got %h want 0", io_strobe); end
    checks++; if (io_out !== 8'h00) begin errors++; $display("FAIL preboot_io got %h want 00", io_out); end
    // Must restart from the length byte: a stale FSM would take 04 as image data
    sendByte(8'h04, 0);
    for (int i = 0; i < 4; i++) begin
      imemModel[i] = 8'h40 + 8'(i);
      sendByte(imemModel[i], 0);
      checks++;
      if (cpu_run !== (i == 3)) begin errors++; $display("FAIL partial_boot%0d got %h want %h", i, cpu_run, (i == 3)); end
    end
    for (int a = 0; a < 4; a++) begin
      PC_inst = 8'(a);
      #1;
      checks++;
      if (saidaInstruction !== imemModel[a]) begin
        errors++; $display("FAIL partial_fetch[%0d] got %h want %h", a, saidaInstruction, imemModel[a]);
      end
    end
    LEmem = 1'b1; endereco = 8'h20;
    #1;
    checks++; if (saidaDadoMem !== 8'h11) begin errors++; $display("FAIL preboot_store got %h want 11", saidaDadoMem); end
    endereco = 8'hFF;
    #1;
    checks++; if (saidaDadoMem !== 8'h00) begin errors++; $display("FAIL preboot_ioload got %h want 00", saidaDadoMem); end
    LEmem = 1'b0;
  endtask

  task automatic test_full_image();
    for (int i = 0; i < 256; i++) stim[i] = 8'(i);
    test_boot("full256", 256, 0);
    PC_inst = 8'hFF;
    #1;
    checks++; if (saidaInstruction !== 8'hFF) begin errors++; $display("FAIL full_last got %h want FF", saidaInstruction); end
  endtask

  task automatic test_gaps();
    int n;
    n = $urandom_range(5, 60);
    for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
    test_boot("gaps", n, 3);
    storeWord(8'hFF, 8'h81); ioModel = 8'h81;
    checks++; if (io_out !== ioModel) begin errors++; $display("FAIL gaps_io got %h want %h", io_out, ioModel); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmemKnown[i] = 1'b0; dmemModel[i] = '0; imemModel[i] = '0; stim[i] = '0;
    end
    test_reset();
    test_boot_short();
    test_data_ram();
    test_io();
    test_partial_reset();
    test_full_image();
    test_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
